// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master side issues operations; the slave side (the subtractor) returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock with a registered borrow.
// A start/busy/done handshake frames each WIDTH/DIGIT-cycle operation.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;

  logic [DIGIT:0]   dig_s;
  logic [WIDTH-1:0] res_next_s;

  // One DIGIT-wide subtractor slice; the extra top bit of dig_s is the borrow out.
  always_comb begin
    dig_s      = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_r};
    res_next_s = WIDTH'({dig_s[DIGIT-1:0], res_r} >> DIGIT);
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            borrow_r <= bus.bin;
            a_msb_r  <= bus.a[WIDTH-1];
            b_msb_r  <= bus.b[WIDTH-1];
            res_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          a_r      <= a_r >> DIGIT;
          b_r      <= b_r >> DIGIT;
          res_r    <= res_next_s;
          borrow_r <= dig_s[DIGIT];
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            diff_r  <= res_next_s;
            bout_r  <= dig_s[DIGIT];
            zero_r  <= (res_next_s == '0);
            // Signed overflow only when operand signs differ and the result sign leaves a's sign.
            ovf_r   <= (a_msb_r != b_msb_r) && (res_next_s[WIDTH-1] != a_msb_r);
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.zero = zero_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor in three WIDTH/DIGIT configurations,
// using a queue of model results popped at each done pulse.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_v = 1'b0;
  logic [7:0] a_v     = 8'h00;
  logic [7:0] b_v     = 8'h00;
  logic       bin_v   = 1'b0;
  int         sel     = 0;

  serial_subtractor_if #(.WIDTH(8)) if81 ();
  serial_subtractor_if #(.WIDTH(8)) if84 ();
  serial_subtractor_if #(.WIDTH(4)) if42 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst(rst), .bus(if81));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst(rst), .bus(if84));
  serial_subtractor #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst(rst), .bus(if42));

  assign if81.start = start_v && (sel == 0);
  assign if84.start = start_v && (sel == 1);
  assign if42.start = start_v && (sel == 2);
  assign if81.a = a_v;
  assign if84.a = a_v;
  assign if42.a = a_v[3:0];
  assign if81.b = b_v;
  assign if84.b = b_v;
  assign if42.b = b_v[3:0];
  assign if81.bin = bin_v;
  assign if84.bin = bin_v;
  assign if42.bin = bin_v;

  logic       obs_busy, obs_done, obs_bout, obs_zero, obs_ovf;
  logic [7:0] obs_diff;

  always_comb begin
    case (sel)
      0: begin
        obs_busy = if81.busy; obs_done = if81.done; obs_diff = if81.diff;
        obs_bout = if81.bout; obs_zero = if81.zero; obs_ovf  = if81.ovf;
      end
      1: begin
        obs_busy = if84.busy; obs_done = if84.done; obs_diff = if84.diff;
        obs_bout = if84.bout; obs_zero = if84.zero; obs_ovf  = if84.ovf;
      end
      default: begin
        obs_busy = if42.busy; obs_done = if42.done; obs_diff = {4'h0, if42.diff};
        obs_bout = if42.bout; obs_zero = if42.zero; obs_ovf  = if42.ovf;
      end
    endcase
  end

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } res_t;

  res_t sb[$];
  res_t last_exp[3];
  int   total = 0;
  int   bad   = 0;

  function automatic int width_of(input int s);
    return (s == 2) ? 4 : 8;
  endfunction

  function automatic int cycles_of(input int s);
    return (s == 0) ? 8 : 2;
  endfunction

  // Behavioural reference working on plain integers.
  function automatic res_t model(input int w, input int av, input int bv, input int binv);
    res_t m;
    int   mask = (1 << w) - 1;
    int   half = 1 << (w - 1);
    int   full = av - bv - binv;
    int   sa   = (av >= half) ? av - (1 << w) : av;
    int   sb_  = (bv >= half) ? bv - (1 << w) : bv;
    int   sd   = sa - sb_ - binv;
    m.diff = 8'(full & mask);
    m.bout = (full < 0);
    m.zero = ((full & mask) == 0);
    m.ovf  = (sd < -half) || (sd > half - 1);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input res_t exp);
    chk({tag, "_diff"}, 32'(obs_diff), 32'(exp.diff));
    chk({tag, "_bout"}, 32'(obs_bout), 32'(exp.bout));
    chk({tag, "_zero"}, 32'(obs_zero), 32'(exp.zero));
    chk({tag, "_ovf"},  32'(obs_ovf),  32'(exp.ovf));
  endtask

  // Issue one operation at a negedge, scramble inputs after capture, wait for done and score it.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic binv, input bit hold);
    res_t exp_r;
    int   k;
    a_v = av; b_v = bv; bin_v = binv; start_v = 1'b1;
    sb.push_back(model(width_of(sel), int'(av), int'(bv), int'(binv)));
    @(negedge clk);
    chk("busy_after_start", 32'(obs_busy), 32'd1);
    chk("done_low_after_start", 32'(obs_done), 32'd0);
    chk("diff_held_while_run", 32'(obs_diff), 32'(last_exp[sel].diff));
    start_v = hold;
    a_v = ~av; b_v = bv ^ 8'h5A; bin_v = ~binv;
    k = 1;
    while (obs_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    // Accept edge plus N RUN edges.
    chk("latency", 32'(k), 32'(cycles_of(sel) + 1));
    chk("busy_low_at_done", 32'(obs_busy), 32'd0);
    exp_r = sb.pop_front();
    chk_outputs("result", exp_r);
    last_exp[sel] = exp_r;
    start_v = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (obs_done === 1'b1) n++;
    end
  endtask

  initial begin
    int ndone;
    for (int s = 0; s < 3; s++) last_exp[s] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_busy", 32'(obs_busy), 32'd0);
      chk("reset_done", 32'(obs_done), 32'd0);
      chk_outputs("reset", '0);
    end
    @(negedge clk);

    // WIDTH=8, DIGIT=1 directed cases
    sel = 0;
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(obs_done), 32'd0);
    chk_outputs("held_after_done", last_exp[0]);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h80, 1'b0, 1'b0);
    @(negedge clk);

    // WIDTH=8, DIGIT=4 directed cases
    sel = 1;
    #1;
    do_op(8'h03, 8'h02, 1'b1, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    // start held high through RUN yields one done only
    sel = 0;
    #1;
    do_op(8'h5A, 8'h33, 1'b0, 1'b1);
    count_dones(12, ndone);
    chk("single_done_when_held", 32'(ndone), 32'd0);
    chk("idle_after_held", 32'(obs_busy), 32'd0);

    // Reset in mid-operation aborts; rst also wins over a simultaneous start
    a_v = 8'h10; b_v = 8'h01; bin_v = 1'b0; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start_v = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_v = 1'b0;
    chk("abort_busy", 32'(obs_busy), 32'd0);
    chk("abort_done", 32'(obs_done), 32'd0);
    chk_outputs("abort", '0);
    count_dones(12, ndone);
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    for (int s = 0; s < 3; s++) last_exp[s] = '0;
    rst = 1'b1; start_v = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_v = 1'b0;
    chk("rst_beats_start", 32'(obs_busy), 32'd0);
    do_op(8'h10, 8'h01, 1'b0, 1'b0);
    @(negedge clk);

    // WIDTH=4, DIGIT=2 exhaustive, back-to-back
    sel = 2;
    #1;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          do_op(8'(av), 8'(bv), 1'(bi), 1'b0);
        end
      end
    end
    @(negedge clk);
    chk("final_done_low", 32'(obs_done), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
